// File: rtl/bus_transfer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_transfer_controller                                                    |
// | Sequences register-file transfers over a shared tri-state 8-bit bus.       |
// | Optional: define SWAP_OP_EN to enable the two-phase register exchange.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_transfer_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_src,
  input  logic [2:0] req_dst,
  input  logic [7:0] req_imm,
  output logic       gpr_write_data,
  output logic       gpr_read_data,
  output logic [2:0] gpr_output_select,
  output logic [2:0] gpr_input_select,
  inout  wire  [7:0] data_bus,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_RDB = 2'b10;
  localparam logic [1:0] OP_SWP = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SRC0 = 3'd1,
`ifdef SWAP_OP_EN
    SRC1 = 3'd2,
    DST1 = 3'd4,
`endif
    DST0 = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] src_q, src_d, dst_q, dst_d;
  logic [7:0] imm_q, imm_d, t0_q, t0_d;
`ifdef SWAP_OP_EN
  logic [7:0] t1_q, t1_d;
`endif
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       wr_q, wr_d, rd_q, rd_d, drive_q, drive_d;
  logic [2:0] out_sel_q, out_sel_d, in_sel_q, in_sel_d;
  logic [7:0] bus_out_q, bus_out_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    t0_d        = t0_q;
`ifdef SWAP_OP_EN
    t1_d        = t1_q;
`endif
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d  = req_op;
          src_d = req_src;
          dst_d = req_dst;
          imm_d = req_imm;
          case (req_op)
            OP_LDI:  state_d = DST0;
            OP_SWP: begin
`ifdef SWAP_OP_EN
              state_d = SRC0;
`else
              // Exchange not built: reject immediately without touching the bus.
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = 8'h00;
`endif
            end
            default: state_d = SRC0;
          endcase
        end
      end
      SRC0: begin
        t0_d = data_bus;
        if (op_q == OP_RDB) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_bus;
`ifdef SWAP_OP_EN
        end else if (op_q == OP_SWP) begin
          state_d = SRC1;
`endif
        end else begin
          state_d = DST0;
        end
      end
`ifdef SWAP_OP_EN
      SRC1: begin
        t1_d    = data_bus;
        state_d = DST0;
      end
      DST1: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = t0_q;
      end
`endif
      DST0: begin
`ifdef SWAP_OP_EN
        if (op_q == OP_SWP) begin
          state_d = DST1;
        end else begin
`else
        begin
`endif
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_LDI) ? imm_q : t0_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus-side outputs are registered from the state being entered.
    req_ready_d = (state_d == IDLE);
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    drive_d     = 1'b0;
    out_sel_d   = 3'd0;
    in_sel_d    = 3'd0;
    bus_out_d   = 8'h00;
    case (state_d)
      SRC0: begin
        wr_d      = 1'b1;
        out_sel_d = src_d;
      end
      DST0: begin
        rd_d    = 1'b1;
        drive_d = 1'b1;
`ifdef SWAP_OP_EN
        in_sel_d  = (op_d == OP_SWP) ? src_d : dst_d;
        bus_out_d = (op_d == OP_LDI) ? imm_d : ((op_d == OP_SWP) ? t1_d : t0_d);
`else
        in_sel_d  = dst_d;
        bus_out_d = (op_d == OP_LDI) ? imm_d : t0_d;
`endif
      end
`ifdef SWAP_OP_EN
      SRC1: begin
        wr_d      = 1'b1;
        out_sel_d = dst_d;
      end
      DST1: begin
        rd_d      = 1'b1;
        drive_d   = 1'b1;
        in_sel_d  = dst_d;
        bus_out_d = t0_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      src_q       <= 3'd0;
      dst_q       <= 3'd0;
      imm_q       <= 8'h00;
      t0_q        <= 8'h00;
`ifdef SWAP_OP_EN
      t1_q        <= 8'h00;
`endif
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'h00;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      drive_q     <= 1'b0;
      out_sel_q   <= 3'd0;
      in_sel_q    <= 3'd0;
      bus_out_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      t0_q        <= t0_d;
`ifdef SWAP_OP_EN
      t1_q        <= t1_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      drive_q     <= drive_d;
      out_sel_q   <= out_sel_d;
      in_sel_q    <= in_sel_d;
      bus_out_q   <= bus_out_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_err           = rsp_err_q;
  assign rsp_data          = rsp_data_q;
  assign gpr_write_data    = wr_q;
  assign gpr_read_data     = rd_q;
  assign gpr_output_select = out_sel_q;
  assign gpr_input_select  = in_sel_q;
  assign data_bus          = drive_q ? bus_out_q : 8'hzz;

endmodule
`default_nettype wire
